// File: rtl/cfg_mux_pkg.sv
// Shared definitions for the cfg_muxn_bank routing-mux bank.
//  clog2       : elaboration-time ceiling log2 for select/counter widths
//  cfg_word_w  : per-channel config word width (select, plus regout bit if enabled)
//  REGOUT_EN   : 1 when built with CFGMUX_REGOUT_EN (registered-output option)
//  SEL_INVALID_OUT : value driven on a channel whose select is out of range
package cfg_mux_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int cfg_word_w(input int swidth, input bit regout);
    return swidth + (regout ? 1 : 0);
  endfunction

`ifdef CFGMUX_REGOUT_EN
  localparam bit REGOUT_EN = 1'b1;
`else
  localparam bit REGOUT_EN = 1'b0;
`endif

  // Out-of-range selects drive a quiet 0 rather than an arbitrary input.
  localparam logic SEL_INVALID_OUT = 1'b0;

endpackage

// File: rtl/cfg_muxn_bank_muxn.sv
// muxn: one IWIDTH:1 routing mux channel.
//  I   : shared routing inputs
//  sel : channel select
//  O   : I[sel], or SEL_INVALID_OUT when sel >= IWIDTH
//  err : high when sel >= IWIDTH
module muxn
  import cfg_mux_pkg::*;
#(
  parameter int IWIDTH = 37,
  parameter int SWIDTH = clog2(IWIDTH)
) (
  input  logic [IWIDTH-1:0] I,
  input  logic [SWIDTH-1:0] sel,
  output logic              O,
  output logic              err
);

  // Compare against every legal index so unused select codes fall through
  // to the invalid default without any out-of-range part select.
  always_comb begin
    O   = SEL_INVALID_OUT;
    err = 1'b1;
    for (int i = 0; i < IWIDTH; i++) begin
      if (sel == SWIDTH'(i)) begin
        O   = I[i];
        err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cfg_muxn_bank.sv
// cfg_muxn_bank: NOUT-channel bank of IWIDTH:1 routing muxes with a
// double-buffered serial config chain (shift into shadow, commit to active).
// Optional feature macro: CFGMUX_REGOUT_EN (adds a per-channel regout bit and
// output flops; without it every output is combinational).
// Ports:
//  clk, rst_n  : clock, async active-low reset
//  I           : shared routing inputs
//  O           : channel outputs
//  cfg_en      : shift enable;  cfg_in : serial data in
//  cfg_out     : serial data out (shadow MSB, feeds next tile)
//  cfg_commit  : copy shadow to active
//  cfg_full    : exactly L bits shifted since reset/commit (saturating)
//  sel_err     : per-channel active select out of range
module cfg_muxn_bank
  import cfg_mux_pkg::*;
#(
  parameter int IWIDTH = 37,
  parameter int SWIDTH = clog2(IWIDTH),
  parameter int NOUT   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IWIDTH-1:0] I,
  output logic [NOUT-1:0]   O,
  input  logic              cfg_en,
  input  logic              cfg_in,
  output logic              cfg_out,
  input  logic              cfg_commit,
  output logic              cfg_full,
  output logic [NOUT-1:0]   sel_err
);

  localparam int CW    = cfg_word_w(SWIDTH, REGOUT_EN);
  localparam int L     = NOUT * CW;
  localparam int CNT_W = clog2(L + 1);
  localparam logic [CNT_W-1:0] L_CNT = CNT_W'(L);

  logic [L-1:0]     shadow;
  logic [L-1:0]     active;
  logic [CNT_W-1:0] count;
  logic [NOUT-1:0]  mux_o;

  // Commit samples the pre-edge shadow, so a simultaneous shift lands only in
  // the shadow and is counted as the first bit of the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
      count  <= '0;
    end else begin
      if (cfg_en) shadow <= {shadow[L-2:0], cfg_in};
      if (cfg_commit) begin
        active <= shadow;
        count  <= cfg_en ? CNT_W'(1) : '0;
      end else if (cfg_en && count != L_CNT) begin
        count <= count + CNT_W'(1);
      end
    end
  end

  assign cfg_out  = shadow[L-1];
  assign cfg_full = (count == L_CNT);

  for (genvar c = 0; c < NOUT; c++) begin : g_ch
    muxn #(
      .IWIDTH (IWIDTH),
      .SWIDTH (SWIDTH)
    ) u_mux (
      .I   (I),
      .sel (active[c*CW +: SWIDTH]),
      .O   (mux_o[c]),
      .err (sel_err[c])
    );
  end

`ifdef CFGMUX_REGOUT_EN
  logic [NOUT-1:0] o_q;
  logic [NOUT-1:0] regout;

  // Flops run unconditionally so switching regout on presents an
  // already-valid sample instead of a stale reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_q <= '0;
    else        o_q <= mux_o;
  end

  for (genvar c = 0; c < NOUT; c++) begin : g_reg
    assign regout[c] = active[c*CW + CW - 1];
    assign O[c]      = regout[c] ? o_q[c] : mux_o[c];
  end
`else
  assign O = mux_o;
`endif

endmodule

// File: tb/tb_cfg_muxn_bank.sv
module tb_cfg_muxn_bank;

  localparam int IW = 37;
  localparam int SW = 6;
  localparam int NO = 4;
`ifdef CFGMUX_REGOUT_EN
  localparam int CW = SW + 1;
`else
  localparam int CW = SW;
`endif
  localparam int L = NO * CW;

  logic          clk;
  logic          rst_n;
  logic [IW-1:0] i_bus;
  logic [NO-1:0] o;
  logic          cfg_en;
  logic          cfg_in;
  logic          cfg_out;
  logic          cfg_commit;
  logic          cfg_full;
  logic [NO-1:0] sel_err;

  cfg_muxn_bank #(.IWIDTH(IW), .NOUT(NO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .I          (i_bus),
    .O          (o),
    .cfg_en     (cfg_en),
    .cfg_in     (cfg_in),
    .cfg_out    (cfg_out),
    .cfg_commit (cfg_commit),
    .cfg_full   (cfg_full),
    .sel_err    (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] o, ocare, err, errcare;
    logic       full, fullcare, cout, coutcare;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if ((((o ^ e.o) & e.ocare) != 0) || (((sel_err ^ e.err) & e.errcare) != 0) ||
          (e.fullcare && cfg_full !== e.full) || (e.coutcare && cfg_out !== e.cout)) begin
        errors++;
        $display("FAIL %s: got O=%b err=%b full=%b cout=%b, want O=%b/%b err=%b/%b full=%b/%b cout=%b/%b",
                 e.name, o, sel_err, cfg_full, cfg_out, e.o, e.ocare, e.err, e.errcare,
                 e.full, e.fullcare, e.cout, e.coutcare);
      end
    end
  end

  initial begin
    #200000;
    if (!done) begin
      errors++;
      $display("FAIL timeout: stimulus did not complete");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic expect_st(input string name, input logic [3:0] eo, input logic [3:0] ocare,
                           input logic [3:0] eerr, input logic [3:0] errcare,
                           input logic efull, input logic fullcare,
                           input logic ecout, input logic coutcare);
    exp_t e;
    e.name = name; e.o = eo; e.ocare = ocare; e.err = eerr; e.errcare = errcare;
    e.full = efull; e.fullcare = fullcare; e.cout = ecout; e.coutcare = coutcare;
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  function automatic logic [3:0] mdl_o(input logic [IW-1:0] iv, input logic [3:0][SW-1:0] s);
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = (int'(s[c]) < IW) ? iv[s[c]] : 1'b0;
    return r;
  endfunction

  task automatic shift_bit(input logic b);
    cfg_en = 1'b1; cfg_in = b;
    @(posedge clk); #1;
    cfg_en = 1'b0; cfg_in = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    @(posedge clk); #1;
    cfg_commit = 1'b0;
  endtask

  task automatic load_bits(input logic [3:0][SW-1:0] s, input logic [3:0] ro, input int nbits);
    logic [L-1:0] vec;
    vec = '0;
    for (int c = 0; c < NO; c++) begin
      vec[c*CW +: SW] = s[c];
`ifdef CFGMUX_REGOUT_EN
      vec[c*CW + CW - 1] = ro[c];
`endif
    end
    for (int i = L - 1; i >= L - nbits; i--) shift_bit(vec[i]);
  endtask

  logic [3:0][SW-1:0] sl;
  logic [3:0][SW-1:0] sa;

  initial begin
    rst_n = 1'b0; cfg_en = 1'b0; cfg_in = 1'b0; cfg_commit = 1'b0;
    i_bus = 37'h1_0000_F57CE;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) shift_bit(1'b1);
    rst_n = 1'b0;
    #1;
    checks++;
    if (o !== 4'b0000 || cfg_full !== 1'b0 || sel_err !== 4'b0000 || cfg_out !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: O=%b full=%b err=%b cout=%b", o, cfg_full, sel_err, cfg_out);
    end
    expect_st("reset", 4'b0000, 4'hF, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;
    expect_st("post_reset", 4'b0000, 4'hF, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1);

    sl[3] = 6'd3; sl[2] = 6'd1; sl[1] = 6'd2; sl[0] = 6'd5;
    load_bits(sl, 4'b0000, L - 1);
    expect_st("not_full_yet", 4'b0000, 4'hF, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    shift_bit(1'b1);
    expect_st("full_precommit", 4'b0000, 4'hF, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1);
    commit();
    expect_st("load_3125", 4'b1110, 4'hF, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);

    i_bus = 37'h0A_5C3F_96E1;
    for (int s = 0; s < IW; s++) begin
      sl = '0;
      sl[0] = SW'(s);
      load_bits(sl, 4'b0000, L);
      commit();
      expect_st($sformatf("sweep_sel%0d", s), mdl_o(i_bus, sl), 4'hF, 4'h0, 4'hF,
                1'b0, 1'b1, 1'b0, 1'b0);
    end

    sl = '0; sl[2] = 6'd40;
    load_bits(sl, 4'b0000, L);
    commit();
    expect_st("invalid_sel", 4'b1011, 4'hF, 4'b0100, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    sl = '0;
    load_bits(sl, 4'b0000, L);
    commit();
    expect_st("invalid_cleared", 4'b1111, 4'hF, 4'b0000, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);

    sa[3] = 6'd10; sa[2] = 6'd9; sa[1] = 6'd8; sa[0] = 6'd7;
    load_bits(sa, 4'b0000, L);
    cfg_en = 1'b1; cfg_in = 1'b1; cfg_commit = 1'b1;
    @(posedge clk); #1;
    cfg_en = 1'b0; cfg_in = 1'b0; cfg_commit = 1'b0;
    expect_st("same_edge_commit", mdl_o(i_bus, sa), 4'hF, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < L - 2; i++) shift_bit(1'b0);
    expect_st("count_from_one", mdl_o(i_bus, sa), 4'hF, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    shift_bit(1'b0);
    expect_st("cfg_out_delay", mdl_o(i_bus, sa), 4'hF, 4'h0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1);
    shift_bit(1'b0);
    expect_st("overshift", mdl_o(i_bus, sa), 4'hF, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1);

`ifdef CFGMUX_REGOUT_EN
    i_bus = 37'h1_0000_F57CE;
    sl = '0; sl[1] = 6'd5;
    load_bits(sl, 4'b0010, L);
    commit();
    @(posedge clk); #1;
    i_bus[5] = 1'b1;
    expect_st("regout_lag", 4'b0000, 4'b0010, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_st("regout_follow", 4'b0010, 4'b0010, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    i_bus[5] = 1'b0;
    expect_st("regout_lag_fall", 4'b0010, 4'b0010, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_st("regout_fall", 4'b0000, 4'b0010, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    load_bits(sl, 4'b0000, L);
    commit();
    @(posedge clk); #1;
    i_bus[5] = 1'b1;
    expect_st("comb_follow", 4'b0010, 4'b0010, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    @(negedge clk); #1;
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
